// File: rtl/ram_pkg.sv
// Shared constants for the single-port clearable RAM: read-during-write
// selection and the clear sequencer state encoding.
package ram_pkg;

    localparam logic RDW_OLD = 1'b0;
    localparam logic RDW_NEW = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/ram_clr_seq.sv
// Clear sequencer: walks an address counter over the whole array once per
// sweep, started by reset (optionally) or by a one-cycle request while idle.
module ram_clr_seq
    import ram_pkg::*;
#(
    parameter int   AW           = 8,
    parameter logic CLR_ON_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clr_req,
    output logic          busy,
    output logic [AW-1:0] clr_addr,
    output logic          clr_we
);

    localparam logic [AW-1:0] CNT_LAST = {AW{1'b1}};

    clr_state_t    state_r;
    logic [AW-1:0] cnt_r;
    logic          busy_r;

    // State, sweep counter and registered busy flag
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_r   <= '0;
            state_r <= CLR_ON_RESET ? ST_CLEAR : ST_IDLE;
            busy_r  <= CLR_ON_RESET;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (clr_req) begin
                        state_r <= ST_CLEAR;
                        busy_r  <= 1'b1;
                        cnt_r   <= '0;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    // Last address written on this edge: wrap and drop busy together
                    cnt_r <= cnt_r + AW'(1);
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_CLEAR;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign clr_we   = busy_r;
    assign clr_addr = cnt_r;

endmodule

// File: rtl/ram_sp_clr.sv
// Parametrised single-port synchronous RAM with selectable read-during-write
// behaviour and a built-in clear sweep sharing the single write port.
module ram_sp_clr
    import ram_pkg::*;
#(
    parameter int            AW           = 8,
    parameter int            DW           = 8,
    parameter logic [DW-1:0] CLR_VALUE    = '0,
    parameter logic          CLR_ON_RESET = 1'b1,
    parameter logic          RDW_MODE     = RDW_OLD
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] a,
    input  logic [DW-1:0] i,
    output logic [DW-1:0] o,
    input  logic          r_n,
    input  logic          w_n,
    input  logic          clr_req,
    output logic          busy
);

    logic          busy_s;
    logic          clr_we_s;
    logic [AW-1:0] clr_addr_s;
    logic          we_s;
    logic [AW-1:0] addr_s;
    logic [DW-1:0] wdata_s;
    logic [DW-1:0] o_r;
    logic [DW-1:0] mem_r [0:(2**AW)-1];

    ram_clr_seq #(
        .AW           (AW),
        .CLR_ON_RESET (CLR_ON_RESET)
    ) u_seq (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr_req  (clr_req),
        .busy     (busy_s),
        .clr_addr (clr_addr_s),
        .clr_we   (clr_we_s)
    );

    // Write port mux: the sweep owns the port while busy, reset blocks writes
    always_comb begin
        we_s    = 1'b0;
        addr_s  = a;
        wdata_s = i;
        if (!reset_n) begin
            we_s = 1'b0;
        end else if (busy_s) begin
            we_s    = clr_we_s;
            addr_s  = clr_addr_s;
            wdata_s = CLR_VALUE;
        end else begin
            we_s = !w_n;
        end
    end

    // Array write, kept reset-free so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_r[addr_s] <= wdata_s;
        end
    end

    // Registered read data; holds while idle-unread or sweeping
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            o_r <= '0;
        end else if (!busy_s && !r_n) begin
            if ((RDW_MODE == RDW_NEW) && !w_n) begin
                o_r <= i;
            end else begin
                o_r <= mem_r[a];
            end
        end else begin
            o_r <= o_r;
        end
    end

    assign o    = o_r;
    assign busy = busy_s;

endmodule

// File: tb/tb_ram_sp_clr.sv
// Bench for ram_sp_clr: three configurations checked against an array-based
// reference model that tracks memory contents and remaining sweep length.
module tb_ram_sp_clr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [7:0]  a8, i8, o_a, o_b;
    logic        r_n8, w_n8, clr8, busy_a, busy_b;
    logic [9:0]  a10;
    logic [15:0] i16, o_c;
    logic        r_n_c, w_n_c, clr_c, busy_c;

    int errors = 0;
    int checks = 0;

    // Model: 0 = old-data/clear-on-reset, 1 = write-through/no reset clear, 2 = wide
    logic [15:0] mm [3][1024];
    bit          mv [3][1024];
    logic [15:0] eo [3];
    bit          ev [3];
    int          left [3] = '{0, 0, 0};
    int          pos  [3] = '{0, 0, 0};

    ram_sp_clr #(.AW(8), .DW(8), .CLR_VALUE(8'hA5), .CLR_ON_RESET(1'b1), .RDW_MODE(1'b0)) u_a (
        .clk(clk), .reset_n(rst_n), .a(a8), .i(i8), .o(o_a),
        .r_n(r_n8), .w_n(w_n8), .clr_req(clr8), .busy(busy_a));

    ram_sp_clr #(.AW(8), .DW(8), .CLR_VALUE(8'hA5), .CLR_ON_RESET(1'b0), .RDW_MODE(1'b1)) u_b (
        .clk(clk), .reset_n(rst_n), .a(a8), .i(i8), .o(o_b),
        .r_n(r_n8), .w_n(w_n8), .clr_req(clr8), .busy(busy_b));

    ram_sp_clr #(.AW(10), .DW(16), .CLR_VALUE(16'h0000), .CLR_ON_RESET(1'b1), .RDW_MODE(1'b0)) u_c (
        .clk(clk), .reset_n(rst_n), .a(a10), .i(i16), .o(o_c),
        .r_n(r_n_c), .w_n(w_n_c), .clr_req(clr_c), .busy(busy_c));

    task automatic model_step(input int k, input logic rst, input int aa, input logic [15:0] ii,
                              input logic rn, input logic wn, input logic cl);
        int          depth;
        logic [15:0] clrv;
        logic [15:0] old;
        bit          oldv;
        depth = (k == 2) ? 1024 : 256;
        clrv  = (k == 2) ? 16'h0000 : 16'h00A5;
        if (!rst) begin
            eo[k]   = 16'h0000;
            ev[k]   = 1'b1;
            pos[k]  = 0;
            left[k] = (k != 1) ? depth : 0;
        end else if (left[k] > 0) begin
            mm[k][pos[k]] = clrv;
            mv[k][pos[k]] = 1'b1;
            pos[k]  = (pos[k] + 1) % depth;
            left[k] = left[k] - 1;
        end else begin
            old  = mm[k][aa];
            oldv = mv[k][aa];
            if (!wn) begin
                mm[k][aa] = ii;
                mv[k][aa] = 1'b1;
            end
            if (!rn) begin
                if ((k == 1) && !wn) begin
                    eo[k] = ii;
                    ev[k] = 1'b1;
                end else begin
                    eo[k] = old;
                    ev[k] = oldv;
                end
            end
            if (cl) begin
                left[k] = depth;
                pos[k]  = 0;
            end
        end
    endtask

    task automatic tick;
        @(posedge clk);
        model_step(0, rst_n, int'(a8), {8'h00, i8}, r_n8, w_n8, clr8);
        model_step(1, rst_n, int'(a8), {8'h00, i8}, r_n8, w_n8, clr8);
        model_step(2, rst_n, int'(a10), i16, r_n_c, w_n_c, clr_c);
        #1;
    endtask

    task automatic idle_inputs;
        r_n8 = 1'b1; w_n8 = 1'b1; clr8 = 1'b0;
        r_n_c = 1'b1; w_n_c = 1'b1; clr_c = 1'b0;
    endtask

    task automatic test_reset;
        int na;
        int nc;
        logic [7:0] rd_addr [3];
        rd_addr = '{8'h00, 8'h7F, 8'hFF};
        rst_n = 1'b0; idle_inputs();
        a8 = 8'h00; i8 = 8'h00; a10 = 10'h000; i16 = 16'h0000;
        tick(); tick();
        checks++; if (o_a !== 8'h00) begin errors++; $display("FAIL reset_o_a: got %h want 00", o_a); end
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL reset_busy_a: got %b want 1", busy_a); end
        checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL reset_busy_b: got %b want 0", busy_b); end
        checks++; if (busy_c !== 1'b1) begin errors++; $display("FAIL reset_busy_c: got %b want 1", busy_c); end
        rst_n = 1'b1;
        na = 1; nc = 1;
        for (int n = 0; n < 1100; n++) begin
            tick();
            if (busy_a) na++;
            if (busy_c) nc++;
            checks++; if (o_a !== 8'h00) begin errors++; $display("FAIL sweep_o_zero: got %h want 00", o_a); end
            if (!busy_a && !busy_c) break;
        end
        checks++; if (na != 256) begin errors++; $display("FAIL reset_sweep_len_a: got %0d want 256", na); end
        checks++; if (nc != 1024) begin errors++; $display("FAIL reset_sweep_len_c: got %0d want 1024", nc); end
        for (int j = 0; j < 3; j++) begin
            a8 = rd_addr[j]; r_n8 = 1'b0; tick(); r_n8 = 1'b1;
            checks++; if (o_a !== 8'hA5) begin errors++; $display("FAIL cleared_read %h: got %h want a5", rd_addr[j], o_a); end
        end
    endtask

    task automatic test_write_read;
        a8 = 8'h10; i8 = 8'h3C; w_n8 = 1'b0; tick(); w_n8 = 1'b1;
        r_n8 = 1'b0; tick(); r_n8 = 1'b1;
        checks++; if (o_a !== 8'h3C) begin errors++; $display("FAIL wr_rd_a: got %h want 3c", o_a); end
        checks++; if (o_b !== 8'h3C) begin errors++; $display("FAIL wr_rd_b: got %h want 3c", o_b); end
        for (int n = 0; n < 3; n++) begin
            a8 = 8'($urandom); tick();
            checks++; if (o_a !== 8'h3C) begin errors++; $display("FAIL hold_a: got %h want 3c", o_a); end
        end
    endtask

    task automatic test_rdw;
        a8 = 8'h20; i8 = 8'h11; w_n8 = 1'b0; tick();
        i8 = 8'h22; r_n8 = 1'b0; tick(); w_n8 = 1'b1;
        checks++; if (o_a !== 8'h11) begin errors++; $display("FAIL rdw_old: got %h want 11", o_a); end
        checks++; if (o_b !== 8'h22) begin errors++; $display("FAIL rdw_new: got %h want 22", o_b); end
        tick(); r_n8 = 1'b1;
        checks++; if (o_a !== 8'h22) begin errors++; $display("FAIL rdw_after_a: got %h want 22", o_a); end
        checks++; if (o_b !== 8'h22) begin errors++; $display("FAIL rdw_after_b: got %h want 22", o_b); end
    endtask

    task automatic test_clear_ignore;
        int na;
        int nb;
        clr8 = 1'b1; tick(); clr8 = 1'b0;
        na = busy_a ? 1 : 0;
        nb = busy_b ? 1 : 0;
        for (int c = 1; c < 400; c++) begin
            a8   = (c >= 20 && c <= 30) ? 8'h10 : 8'h05;
            i8   = 8'h99;
            w_n8 = !(c >= 3 && c <= 10);
            r_n8 = !(c >= 20 && c <= 30);
            clr8 = (c == 100);
            tick();
            if (busy_a) na++;
            if (busy_b) nb++;
            checks++; if (o_a !== eo[0][7:0]) begin errors++; $display("FAIL clear_o_hold_a: got %h want %h", o_a, eo[0][7:0]); end
            if (!busy_a && !busy_b) break;
        end
        idle_inputs();
        checks++; if (na != 256) begin errors++; $display("FAIL clr_req_len_a: got %0d want 256", na); end
        checks++; if (nb != 256) begin errors++; $display("FAIL clr_req_len_b: got %0d want 256", nb); end
        a8 = 8'h05; r_n8 = 1'b0; tick(); r_n8 = 1'b1;
        checks++; if (o_a !== 8'hA5) begin errors++; $display("FAIL ignored_write_a: got %h want a5", o_a); end
        checks++; if (o_b !== 8'hA5) begin errors++; $display("FAIL ignored_write_b: got %h want a5", o_b); end
    endtask

    task automatic test_reset_mid;
        int na;
        int nc;
        a8 = 8'h80; i8 = 8'h5A; w_n8 = 1'b0; tick(); w_n8 = 1'b1;
        clr8 = 1'b1; tick(); clr8 = 1'b0;
        for (int c = 1; c < 50; c++) tick();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL mid_reset_busy_a: got %b want 1", busy_a); end
        checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL mid_reset_busy_b: got %b want 0", busy_b); end
        na = busy_a ? 1 : 0;
        nc = busy_c ? 1 : 0;
        for (int n = 0; n < 1100; n++) begin
            tick();
            if (busy_a) na++;
            if (busy_c) nc++;
            if (!busy_a && !busy_c) break;
        end
        checks++; if (na != 256) begin errors++; $display("FAIL mid_reset_len_a: got %0d want 256", na); end
        checks++; if (nc != 1024) begin errors++; $display("FAIL mid_reset_len_c: got %0d want 1024", nc); end
        a8 = 8'h80; r_n8 = 1'b0; tick();
        checks++; if (o_a !== 8'hA5) begin errors++; $display("FAIL mid_reset_80_a: got %h want a5", o_a); end
        checks++; if (o_b !== 8'h5A) begin errors++; $display("FAIL partial_80_b: got %h want 5a", o_b); end
        a8 = 8'h00; tick(); r_n8 = 1'b1;
        checks++; if (o_b !== 8'hA5) begin errors++; $display("FAIL partial_00_b: got %h want a5", o_b); end
    endtask

    task automatic test_wide;
        int nc;
        a10 = 10'h3FF; i16 = 16'hBEEF; w_n_c = 1'b0; tick(); w_n_c = 1'b1;
        r_n_c = 1'b0; tick(); r_n_c = 1'b1;
        checks++; if (o_c !== 16'hBEEF) begin errors++; $display("FAIL wide_wr_rd: got %h want beef", o_c); end
        clr_c = 1'b1; tick(); clr_c = 1'b0;
        nc = busy_c ? 1 : 0;
        for (int n = 0; n < 1100; n++) begin
            tick();
            if (busy_c) nc++;
            else break;
        end
        checks++; if (nc != 1024) begin errors++; $display("FAIL wide_sweep_len: got %0d want 1024", nc); end
        a10 = 10'h000; i16 = 16'h7777; w_n_c = 1'b0; tick(); w_n_c = 1'b1;
        r_n_c = 1'b0; tick();
        checks++; if (o_c !== 16'h7777) begin errors++; $display("FAIL wide_no_extra_write: got %h want 7777", o_c); end
        a10 = 10'h3FF; tick(); r_n_c = 1'b1;
        checks++; if (o_c !== 16'h0000) begin errors++; $display("FAIL wide_cleared_3ff: got %h want 0000", o_c); end
    endtask

    task automatic test_random;
        for (int n = 0; n < 600; n++) begin
            r_n8  = 1'($urandom_range(0, 1));
            w_n8  = 1'($urandom_range(0, 1));
            a8    = 8'($urandom_range(0, 15));
            i8    = 8'($urandom);
            clr8  = ($urandom_range(0, 199) == 0);
            r_n_c = 1'($urandom_range(0, 1));
            w_n_c = 1'($urandom_range(0, 1));
            a10   = 10'($urandom_range(0, 15));
            i16   = 16'($urandom);
            clr_c = ($urandom_range(0, 299) == 0);
            tick();
            if (ev[0]) begin checks++; if (o_a !== eo[0][7:0]) begin errors++; $display("FAIL rand_o_a: got %h want %h", o_a, eo[0][7:0]); end end
            if (ev[1]) begin checks++; if (o_b !== eo[1][7:0]) begin errors++; $display("FAIL rand_o_b: got %h want %h", o_b, eo[1][7:0]); end end
            if (ev[2]) begin checks++; if (o_c !== eo[2]) begin errors++; $display("FAIL rand_o_c: got %h want %h", o_c, eo[2]); end end
            checks++; if (busy_a !== (left[0] > 0)) begin errors++; $display("FAIL rand_busy_a: got %b want %b", busy_a, left[0] > 0); end
            checks++; if (busy_b !== (left[1] > 0)) begin errors++; $display("FAIL rand_busy_b: got %b want %b", busy_b, left[1] > 0); end
            checks++; if (busy_c !== (left[2] > 0)) begin errors++; $display("FAIL rand_busy_c: got %b want %b", busy_c, left[2] > 0); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_rdw();
        test_clear_ignore();
        test_reset_mid();
        test_wide();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
